sram_port_arbiter: RTL and testbench
====================================

Name: sram_port_arbiter

Overview:
- Shares read/write port A of the dual-port SRAM between two requesters:
  - m0: CPU data port (load/store).
  - m1: host loader/debug port.
- Port B (instruction fetch) bypasses this block.
- Does burst-aware arbitration with a hold limit.
- Generates per-requester read-valid strobes that match the SRAM's one-cycle registered-address read latency.

Parameters:
- WIDTH, 16, data width; matches the SRAM WIDTH.
- DEPTH, 8192, SRAM words.
- ADDR_WIDTH, $clog2(DEPTH), address width.
- MAX_BURST, 8, maximum consecutive grants to one owner while the other requester is waiting; minimum 1.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-high reset.
- m0_req  in  1  m0 access request, held until granted.
- m0_we  in  1  m0 write (1) / read (0).
- m0_addr  in  ADDR_WIDTH  m0 word address.
- m0_wdata  in  WIDTH  m0 write data.
- m0_gnt  out  1  m0 access accepted this cycle.
- m0_rvalid  out  1  m0 read data valid.
- m0_rdata  out  WIDTH  m0 read data.
- m1_req, m1_we, m1_addr, m1_wdata, m1_gnt, m1_rvalid, m1_rdata: same as m0, for m1.
- sram_addr_a  out  ADDR_WIDTH  to SRAM addr_a.
- sram_wdata_a  out  WIDTH  to SRAM wdata_a.
- sram_write_en_a  out  1  to SRAM write_en_a.
- sram_rdata_a  in  WIDTH  from SRAM rdata_a.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values:
  - State IDLE; burst counter 0.
  - m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, sram_write_en_a all 0.
  - sram_addr_a 0, sram_wdata_a 0.
- States: IDLE, OWN0, OWN1, held in a registered owner field.
- Grants are combinational from the current state and the req inputs.
- Grant rules:
  - Exactly one gnt at most per cycle.
  - A granted access is issued to the SRAM in the same cycle.
  - gnt=1 means the request is consumed. The requester may change addr/we/wdata, or drop req, in the next cycle.
- IDLE:
  - Only one req: grant it and go to OWNx.
  - Both req: grant m0 (fixed priority) and go to OWN0.
  - Neither: stay IDLE, drive sram_write_en_a=0.
- OWNx (same rules in OWN0 and OWN1):
  - mx_req=1 and (other req=0 or count<MAX_BURST): grant x, count+1.
  - mx_req=1, other req=1 and count==MAX_BURST: grant the other requester, switch owner, count=1.
  - mx_req=0 and other req=1: grant the other, switch, count=1.
  - Both 0: go IDLE, count=0.
- Burst counter:
  - Width $clog2(MAX_BURST+1).
  - Saturates at MAX_BURST while the other requester is idle; no wrap.
  - Reset to 1 on every owner change; reset to 0 on return to IDLE.
- SRAM mux: sram_addr_a, sram_wdata_a and sram_write_en_a (=we & gnt) come from the granted master. With no grant, address and data hold their last values and write_en=0.
- Read latency:
  - A read granted in cycle N gives mx_rvalid=1 in cycle N+1, from a register.
  - m0_rdata and m1_rdata are both wired directly to sram_rdata_a and are qualified by rvalid only.
- Writes: the write completes at the clock edge ending the grant cycle. No rvalid for writes.
- Back-to-back: a read in N+1 of an address written in N returns the new data.
- Reset mid-burst: owner, counter and rvalid clear immediately. No pending rvalid is delivered after reset.

Optional Feature:
- Macro SRAM_ARB_ROUND_ROBIN_EN.
- Defined: on simultaneous requests in IDLE, the winner is the requester not granted most recently. A last_winner register resets to m1, so m0 wins the first tie.
- Not defined: fixed priority, m0 wins IDLE ties.
- Burst-limit rules are identical in both builds.

Decomposition:
- Shared package sram_arb_pkg:
  - State encoding constants ARB_IDLE=2'd0, ARB_OWN0=2'd1, ARB_OWN1=2'd2.
  - Default MAX_BURST constant.
- One sub-module is natural: sram_arb_fsm, holding owner, counter, last_winner and the grant logic.
- The top level does the datapath mux and the rvalid pipeline.

Test Plan:
- Reset, then m0 writes addr 0x0010 = 0xBEEF and reads it back next cycle: m0_gnt in both cycles, m0_rvalid=1 one cycle after the read grant, m0_rdata=0xBEEF.
- m0 and m1 both request in IDLE: m0_gnt=1, m1_gnt=0. With SRAM_ARB_ROUND_ROBIN_EN defined, after an m0 win the next tie goes to m1.
- MAX_BURST=8, m1 streams reads while m0 requests continuously: m1 gets exactly 8 consecutive grants, then m0 is granted on the 9th cycle.
- m1 holds req alone for 20 cycles: 20 consecutive grants. The counter saturates at 8 and there is no forced switch.
- Assert rst while a read is granted in cycle N: no m0_rvalid/m1_rvalid in N+1, all outputs at reset values, and the first grant after reset is served normally.
- m1 writes 0x1234 to 0x1FFF (top address), then m0 reads 0x1FFF: m0_rvalid with m0_rdata=0x1234, and m1_rvalid stays 0 throughout.

Source files
------------

// File: rtl/sram_arb_pkg.sv
// Shared encodings and defaults for the SRAM port-A arbiter.
package sram_arb_pkg;

  localparam int SRAM_ARB_MAX_BURST = 8;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_OWN0 = 2'd1,
    ARB_OWN1 = 2'd2
  } arb_state_t;

endpackage

// File: rtl/sram_arb_fsm.sv
// Owner/burst-count state machine and combinational grant logic for port A.
// SRAM_ARB_ROUND_ROBIN_EN: IDLE ties go to the requester not granted most recently.
module sram_arb_fsm
  import sram_arb_pkg::*;
#(
  parameter int MAX_BURST = SRAM_ARB_MAX_BURST
) (
  input  logic clk,
  input  logic rst,
  input  logic m0_req,
  input  logic m1_req,
  output logic m0_gnt,
  output logic m1_gnt
);

  localparam int CNT_W = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BURST);
  localparam logic [CNT_W-1:0] ONE_CNT = CNT_W'(1);

  arb_state_t       state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             tie_pick1;

`ifdef SRAM_ARB_ROUND_ROBIN_EN
  logic last_win1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      last_win1 <= 1'b1;
    else if (m0_gnt)
      last_win1 <= 1'b0;
    else if (m1_gnt)
      last_win1 <= 1'b1;
  end

  assign tie_pick1 = ~last_win1;
`else
  assign tie_pick1 = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ARB_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    m0_gnt  = 1'b0;
    m1_gnt  = 1'b0;
    case (state)
      ARB_OWN0: begin
        if (m0_req && (!m1_req || cnt < MAX_CNT)) begin
          m0_gnt = 1'b1;
          if (cnt < MAX_CNT) cnt_n = cnt + ONE_CNT;
        end else if (m1_req) begin
          m1_gnt  = 1'b1;
          state_n = ARB_OWN1;
          cnt_n   = ONE_CNT;
        end else begin
          state_n = ARB_IDLE;
          cnt_n   = '0;
        end
      end
      ARB_OWN1: begin
        if (m1_req && (!m0_req || cnt < MAX_CNT)) begin
          m1_gnt = 1'b1;
          if (cnt < MAX_CNT) cnt_n = cnt + ONE_CNT;
        end else if (m0_req) begin
          m0_gnt  = 1'b1;
          state_n = ARB_OWN0;
          cnt_n   = ONE_CNT;
        end else begin
          state_n = ARB_IDLE;
          cnt_n   = '0;
        end
      end
      default: begin
        if (m0_req && (!m1_req || !tie_pick1)) begin
          m0_gnt  = 1'b1;
          state_n = ARB_OWN0;
          cnt_n   = ONE_CNT;
        end else if (m1_req) begin
          m1_gnt  = 1'b1;
          state_n = ARB_OWN1;
          cnt_n   = ONE_CNT;
        end else begin
          state_n = ARB_IDLE;
          cnt_n   = '0;
        end
      end
    endcase
    // Grants are combinational, so hold them off while reset is asserted.
    if (rst) begin
      m0_gnt = 1'b0;
      m1_gnt = 1'b0;
    end
  end

endmodule

// File: rtl/sram_port_arbiter.sv
// Shares SRAM port A between CPU data (m0) and host loader (m1); muxes the port, pipelines rvalid.
// Optional macro SRAM_ARB_ROUND_ROBIN_EN selects round-robin IDLE tie-breaking.
module sram_port_arbiter
  import sram_arb_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int DEPTH      = 8192,
  parameter int ADDR_WIDTH = $clog2(DEPTH),
  parameter int MAX_BURST  = SRAM_ARB_MAX_BURST
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  m0_req,
  input  logic                  m0_we,
  input  logic [ADDR_WIDTH-1:0] m0_addr,
  input  logic [WIDTH-1:0]      m0_wdata,
  output logic                  m0_gnt,
  output logic                  m0_rvalid,
  output logic [WIDTH-1:0]      m0_rdata,
  input  logic                  m1_req,
  input  logic                  m1_we,
  input  logic [ADDR_WIDTH-1:0] m1_addr,
  input  logic [WIDTH-1:0]      m1_wdata,
  output logic                  m1_gnt,
  output logic                  m1_rvalid,
  output logic [WIDTH-1:0]      m1_rdata,
  output logic [ADDR_WIDTH-1:0] sram_addr_a,
  output logic [WIDTH-1:0]      sram_wdata_a,
  output logic                  sram_write_en_a,
  input  logic [WIDTH-1:0]      sram_rdata_a
);

  logic                  gnt0, gnt1;
  logic [ADDR_WIDTH-1:0] addr_hold;
  logic [WIDTH-1:0]      wdata_hold;
  logic                  rd0_vld_p1, rd1_vld_p1;

  sram_arb_fsm #(
    .MAX_BURST(MAX_BURST)
  ) u_fsm (
    .clk    (clk),
    .rst    (rst),
    .m0_req (m0_req),
    .m1_req (m1_req),
    .m0_gnt (gnt0),
    .m1_gnt (gnt1)
  );

  assign m0_gnt = gnt0;
  assign m1_gnt = gnt1;

  always_comb begin
    sram_addr_a     = addr_hold;
    sram_wdata_a    = wdata_hold;
    sram_write_en_a = 1'b0;
    if (gnt0) begin
      sram_addr_a     = m0_addr;
      sram_wdata_a    = m0_wdata;
      sram_write_en_a = m0_we;
    end else if (gnt1) begin
      sram_addr_a     = m1_addr;
      sram_wdata_a    = m1_wdata;
      sram_write_en_a = m1_we;
    end
  end

  // Stage p1: SRAM registers the address, so read data appears one cycle after the grant.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_hold  <= '0;
      wdata_hold <= '0;
      rd0_vld_p1 <= 1'b0;
      rd1_vld_p1 <= 1'b0;
    end else begin
      if (gnt0 || gnt1) begin
        addr_hold  <= sram_addr_a;
        wdata_hold <= sram_wdata_a;
      end
      rd0_vld_p1 <= gnt0 & ~m0_we;
      rd1_vld_p1 <= gnt1 & ~m1_we;
    end
  end

  assign m0_rvalid = rd0_vld_p1;
  assign m1_rvalid = rd1_vld_p1;
  assign m0_rdata  = sram_rdata_a;
  assign m1_rdata  = sram_rdata_a;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Self-checking bench for sram_port_arbiter with a behavioural registered-read SRAM on port A.
module tb_sram_port_arbiter;

  localparam int AW = 13;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          m0_req = 0, m0_we = 0, m1_req = 0, m1_we = 0;
  logic [AW-1:0] m0_addr = '0, m1_addr = '0;
  logic [DW-1:0] m0_wdata = '0, m1_wdata = '0;
  logic          m0_gnt, m0_rvalid, m1_gnt, m1_rvalid, sram_write_en_a;
  logic [DW-1:0] m0_rdata, m1_rdata, sram_wdata_a, sram_rdata_a;
  logic [AW-1:0] sram_addr_a;

  sram_port_arbiter dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .sram_addr_a(sram_addr_a), .sram_wdata_a(sram_wdata_a),
    .sram_write_en_a(sram_write_en_a), .sram_rdata_a(sram_rdata_a)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] mem    [0:(1<<AW)-1];
  logic [DW-1:0] shadow [0:(1<<AW)-1];

  always @(posedge clk) begin
    if (sram_write_en_a) mem[sram_addr_a] <= sram_wdata_a;
    sram_rdata_a <= mem[sram_addr_a];
  end

  typedef struct {
    logic          r0, w0;
    logic [AW-1:0] a0;
    logic [DW-1:0] d0;
    logic          r1, w1;
    logic [AW-1:0] a1;
    logic [DW-1:0] d1;
    logic          eg0, eg1;
  } vec_t;

  typedef struct {
    logic          m;
    logic [DW-1:0] d;
  } exp_t;

  exp_t          sbq[$];
  int            n_cmp = 0;
  int            n_fail = 0;
  logic          exp_rv0 = 0, exp_rv1 = 0;
  logic [AW-1:0] hold_addr = '0;
  logic [DW-1:0] hold_wdata = '0;
  vec_t          vecs[10];

  function automatic vec_t mk(logic r0, logic w0, logic [AW-1:0] a0, logic [DW-1:0] d0,
                              logic r1, logic w1, logic [AW-1:0] a1, logic [DW-1:0] d1,
                              logic eg0, logic eg1);
    vec_t v;
    v.r0 = r0; v.w0 = w0; v.a0 = a0; v.d0 = d0;
    v.r1 = r1; v.w1 = w1; v.a1 = a1; v.d1 = d1;
    v.eg0 = eg0; v.eg1 = eg1;
    return v;
  endfunction

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_rv();
    exp_t e;
    cmp("m0_rvalid", {31'd0, m0_rvalid}, {31'd0, exp_rv0});
    cmp("m1_rvalid", {31'd0, m1_rvalid}, {31'd0, exp_rv1});
    if (m0_rvalid || m1_rvalid) begin
      if (sbq.size() == 0) begin
        cmp("sb_nonempty", 32'd0, 32'd1);
      end else begin
        e = sbq.pop_front();
        cmp("rvalid_owner", {31'd0, m1_rvalid}, {31'd0, e.m});
        cmp("rdata", {16'd0, (m1_rvalid ? m1_rdata : m0_rdata)}, {16'd0, e.d});
      end
    end
    exp_rv0 = 0;
    exp_rv1 = 0;
  endtask

  task automatic grant_effects(input vec_t v);
    logic          we_e;
    we_e = (v.eg0 & v.w0) | (v.eg1 & v.w1);
    if (v.eg0) begin hold_addr = v.a0; hold_wdata = v.d0; end
    else if (v.eg1) begin hold_addr = v.a1; hold_wdata = v.d1; end
    cmp("sram_write_en_a", {31'd0, sram_write_en_a}, {31'd0, we_e});
    cmp("sram_addr_a", {19'd0, sram_addr_a}, {19'd0, hold_addr});
    cmp("sram_wdata_a", {16'd0, sram_wdata_a}, {16'd0, hold_wdata});
    if (v.eg0 && !v.w0) begin sbq.push_back('{1'b0, shadow[v.a0]}); exp_rv0 = 1; end
    if (v.eg1 && !v.w1) begin sbq.push_back('{1'b1, shadow[v.a1]}); exp_rv1 = 1; end
    if (v.eg0 && v.w0) shadow[v.a0] = v.d0;
    if (v.eg1 && v.w1) shadow[v.a1] = v.d1;
  endtask

  task automatic step(input vec_t v);
    @(negedge clk);
    check_rv();
    m0_req = v.r0; m0_we = v.w0; m0_addr = v.a0; m0_wdata = v.d0;
    m1_req = v.r1; m1_we = v.w1; m1_addr = v.a1; m1_wdata = v.d1;
    #1;
    cmp("m0_gnt", {31'd0, m0_gnt}, {31'd0, v.eg0});
    cmp("m1_gnt", {31'd0, m1_gnt}, {31'd0, v.eg1});
    grant_effects(v);
  endtask

  vec_t idle_v;

  initial begin
    for (int i = 0; i < (1 << AW); i++) begin
      mem[i] = '0;
      shadow[i] = '0;
    end
    idle_v = mk(0, 0, 13'h0, 16'h0, 0, 0, 13'h0, 16'h0, 0, 0);

    vecs[0] = mk(1, 0, 13'h0010, 16'h0, 1, 0, 13'h0020, 16'h0, 1, 0);
    vecs[1] = idle_v;
`ifdef SRAM_ARB_ROUND_ROBIN_EN
    vecs[2] = mk(1, 0, 13'h0030, 16'h0, 1, 0, 13'h0040, 16'h0, 0, 1);
`else
    vecs[2] = mk(1, 0, 13'h0030, 16'h0, 1, 0, 13'h0040, 16'h0, 1, 0);
`endif
    vecs[3] = idle_v;
    vecs[4] = mk(1, 1, 13'h0010, 16'hBEEF, 0, 0, 13'h0, 16'h0, 1, 0);
    vecs[5] = mk(1, 0, 13'h0010, 16'h0, 0, 0, 13'h0, 16'h0, 1, 0);
    vecs[6] = idle_v;
    vecs[7] = mk(0, 0, 13'h0, 16'h0, 1, 1, 13'h1FFF, 16'h1234, 0, 1);
    vecs[8] = mk(1, 0, 13'h1FFF, 16'h0, 0, 0, 13'h0, 16'h0, 1, 0);
    vecs[9] = idle_v;

    // Reset state
    #1;
    cmp("rst_m0_gnt", {31'd0, m0_gnt}, 32'd0);
    cmp("rst_m1_gnt", {31'd0, m1_gnt}, 32'd0);
    cmp("rst_m0_rvalid", {31'd0, m0_rvalid}, 32'd0);
    cmp("rst_m1_rvalid", {31'd0, m1_rvalid}, 32'd0);
    cmp("rst_we", {31'd0, sram_write_en_a}, 32'd0);
    cmp("rst_addr", {19'd0, sram_addr_a}, 32'd0);
    cmp("rst_wdata", {16'd0, sram_wdata_a}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 0;

    for (int i = 0; i < 10; i++) step(vecs[i]);

    // m1 streams reads while m0 waits: 8 m1 grants, then m0
    step(mk(0, 0, 13'h0, 16'h0, 1, 0, 13'h0100, 16'h0, 0, 1));
    for (int k = 1; k < 8; k++)
      step(mk(1, 0, 13'h0200, 16'h0, 1, 0, 13'h0100 + 13'(k), 16'h0, 0, 1));
    step(mk(1, 0, 13'h0200, 16'h0, 1, 0, 13'h0108, 16'h0, 1, 0));
    step(idle_v);

    // m1 alone for 20 cycles: counter saturates, no forced switch
    for (int k = 0; k < 20; k++)
      step(mk(0, 0, 13'h0, 16'h0, 1, 0, 13'h1FFF - 13'(k), 16'h0, 0, 1));
    step(idle_v);

    // Reset asserted during a granted read
    @(negedge clk);
    check_rv();
    m0_req = 1; m0_we = 0; m0_addr = 13'h0010; m0_wdata = 16'h5A5A;
    m1_req = 0; m1_we = 0; m1_addr = '0; m1_wdata = '0;
    #1;
    cmp("pre_rst_m0_gnt", {31'd0, m0_gnt}, 32'd1);
    rst = 1;
    #1;
    hold_addr = '0; hold_wdata = '0;
    cmp("mid_rst_m0_gnt", {31'd0, m0_gnt}, 32'd0);
    cmp("mid_rst_m1_gnt", {31'd0, m1_gnt}, 32'd0);
    cmp("mid_rst_we", {31'd0, sram_write_en_a}, 32'd0);
    cmp("mid_rst_addr", {19'd0, sram_addr_a}, 32'd0);
    cmp("mid_rst_wdata", {16'd0, sram_wdata_a}, 32'd0);
    @(negedge clk);
    cmp("post_rst_m0_rvalid", {31'd0, m0_rvalid}, 32'd0);
    cmp("post_rst_m1_rvalid", {31'd0, m1_rvalid}, 32'd0);
    rst = 0;
    #1;
    cmp("after_rst_m0_gnt", {31'd0, m0_gnt}, 32'd1);
    grant_effects(mk(1, 0, 13'h0010, 16'h5A5A, 0, 0, 13'h0, 16'h0, 1, 0));
    step(idle_v);
    step(idle_v);

    cmp("sb_drained", sbq.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
